hero_position_unit: RTL and testbench

- Produces the packed two-hero position bus that the level-progress logic consumes:
  - hero_x_pos/hero_y_pos[11:0] = hero A.
  - hero_x_pos/hero_y_pos[23:12] = hero B.
- Accepts that logic's one-cycle hero_rst pulse and returns both heroes to their start tiles, with a respawn freeze.
- Movement is grid-based, one tile per command. Hero B mirrors hero A horizontally.
- Moves are paced by the per-frame tick and gated by the collision unit's block flags.

---
 rtl/hero_position_unit_if.sv | 23 ++
 rtl/hero_position_unit.sv | 157 +++++++++++++++
 tb/tb_hero_position_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/hero_position_unit_if.sv
// Bus between the level/collision logic and the hero position unit.
// The master drives movement requests; the slave returns packed positions and status.
interface hero_position_unit_if;
   logic        frame_tick;
   logic [3:0]  dir;
   logic        blocked_a;
   logic        blocked_b;
   logic        hero_rst;
   logic [23:0] hero_x_pos;
   logic [23:0] hero_y_pos;
   logic        moving;
   logic        frozen;

   modport master (
      output frame_tick, dir, blocked_a, blocked_b, hero_rst,
      input  hero_x_pos, hero_y_pos, moving, frozen
   );

   modport slave (
      input  frame_tick, dir, blocked_a, blocked_b, hero_rst,
      output hero_x_pos, hero_y_pos, moving, frozen
   );
endinterface

// File: rtl/hero_position_unit.sv
// Grid-based two-hero position unit: hero B mirrors hero A horizontally.
// Moves are paced by frame_tick, gated by wall flags and bounds, with respawn freeze.
module hero_position_unit #(
   parameter int unsigned TILE          = 32,
   parameter int unsigned STEP          = 4,
   parameter int unsigned START_A_X     = 290,
   parameter int unsigned START_A_Y     = 364,
   parameter int unsigned START_B_X     = 354,
   parameter int unsigned START_B_Y     = 364,
   parameter int unsigned X_MIN         = 34,
   parameter int unsigned X_MAX         = 610,
   parameter int unsigned Y_MIN         = 108,
   parameter int unsigned Y_MAX         = 428,
   parameter int unsigned FREEZE_FRAMES = 60
) (
   input  logic                clk,
   input  logic                rst_n,
   hero_position_unit_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MOVE = 2'd1, S_FREEZE = 2'd2} state_t;

   localparam logic [11:0] STEP_C   = 12'(STEP);
   localparam logic [7:0]  STEPS_C  = 8'(TILE / STEP);
   localparam logic [7:0]  FREEZE_C = 8'(FREEZE_FRAMES);
   localparam logic [11:0] A_X0     = 12'(START_A_X);
   localparam logic [11:0] A_Y0     = 12'(START_A_Y);
   localparam logic [11:0] B_X0     = 12'(START_B_X);
   localparam logic [11:0] B_Y0     = 12'(START_B_Y);

   // Target-in-bounds test done in 13 bits so x+TILE can never wrap.
   function automatic logic f_move_ok(input logic [3:0] d, input logic [11:0] x, input logic [11:0] y);
      logic [12:0] x13;
      logic [12:0] y13;
      logic        ok;
      x13 = {1'b0, x};
      y13 = {1'b0, y};
      case (d)
         4'b1000: ok = (y13 >= 13'(Y_MIN + TILE));
         4'b0100: ok = ((y13 + 13'(TILE)) <= 13'(Y_MAX));
         4'b0010: ok = (x13 >= 13'(X_MIN + TILE));
         4'b0001: ok = ((x13 + 13'(TILE)) <= 13'(X_MAX));
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t      r_state;
   logic [11:0] r_ax, r_ay, r_bx, r_by;
   logic [3:0]  r_dir_a, r_dir_b;
   logic        r_en_a, r_en_b;
   logic [7:0]  r_step_cnt;
   logic [7:0]  r_freeze_cnt;
   logic        r_moving;
   logic        r_frozen;

   logic        w_onehot;
   logic [3:0]  w_dir_b;
   logic        w_en_a;
   logic        w_en_b;

   assign w_onehot = (bus.dir == 4'b0001) || (bus.dir == 4'b0010) ||
                     (bus.dir == 4'b0100) || (bus.dir == 4'b1000);
   assign w_dir_b  = {bus.dir[3], bus.dir[2], bus.dir[0], bus.dir[1]};
   assign w_en_a   = w_onehot && !bus.blocked_a && f_move_ok(bus.dir, r_ax, r_ay);
   assign w_en_b   = w_onehot && !bus.blocked_b && f_move_ok(w_dir_b, r_bx, r_by);

   // Main FSM: respawn has priority, otherwise everything advances on frame_tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ax         <= A_X0;
         r_ay         <= A_Y0;
         r_bx         <= B_X0;
         r_by         <= B_Y0;
         r_dir_a      <= 4'b0000;
         r_dir_b      <= 4'b0000;
         r_en_a       <= 1'b0;
         r_en_b       <= 1'b0;
         r_step_cnt   <= 8'd0;
         r_freeze_cnt <= 8'd0;
         r_moving     <= 1'b0;
         r_frozen     <= 1'b0;
      end else if (bus.hero_rst) begin
         r_state      <= S_FREEZE;
         r_ax         <= A_X0;
         r_ay         <= A_Y0;
         r_bx         <= B_X0;
         r_by         <= B_Y0;
         r_en_a       <= 1'b0;
         r_en_b       <= 1'b0;
         r_step_cnt   <= 8'd0;
         r_freeze_cnt <= FREEZE_C;
         r_moving     <= 1'b0;
         r_frozen     <= 1'b1;
      end else if (bus.frame_tick) begin
         case (r_state)
            S_IDLE: begin
               if (w_en_a || w_en_b) begin
                  r_dir_a    <= bus.dir;
                  r_dir_b    <= w_dir_b;
                  r_en_a     <= w_en_a;
                  r_en_b     <= w_en_b;
                  r_step_cnt <= STEPS_C;
                  r_moving   <= 1'b1;
                  r_state    <= S_MOVE;
               end
            end
            S_MOVE: begin
               if (r_en_a) begin
                  case (r_dir_a)
                     4'b1000: r_ay <= r_ay - STEP_C;
                     4'b0100: r_ay <= r_ay + STEP_C;
                     4'b0010: r_ax <= r_ax - STEP_C;
                     4'b0001: r_ax <= r_ax + STEP_C;
                     default: r_ax <= r_ax;
                  endcase
               end
               if (r_en_b) begin
                  case (r_dir_b)
                     4'b1000: r_by <= r_by - STEP_C;
                     4'b0100: r_by <= r_by + STEP_C;
                     4'b0010: r_bx <= r_bx - STEP_C;
                     4'b0001: r_bx <= r_bx + STEP_C;
                     default: r_bx <= r_bx;
                  endcase
               end
               r_step_cnt <= r_step_cnt - 8'd1;
               if (r_step_cnt == 8'd1) begin
                  r_moving <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            S_FREEZE: begin
               if (r_freeze_cnt == 8'd1) begin
                  r_freeze_cnt <= 8'd0;
                  r_frozen     <= 1'b0;
                  r_state      <= S_IDLE;
               end else begin
                  r_freeze_cnt <= r_freeze_cnt - 8'd1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_moving <= 1'b0;
               r_frozen <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hero_x_pos = {r_bx, r_ax};
   assign bus.hero_y_pos = {r_by, r_ay};
   assign bus.moving     = r_moving;
   assign bus.frozen     = r_frozen;

endmodule

// File: tb/tb_hero_position_unit.sv
// Directed bench for hero_position_unit: a behavioural model pushes expected
// outputs per clock into a queue, popped and compared after each edge.
module tb_hero_position_unit;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hero_position_unit_if u_if();

   hero_position_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   typedef struct {
      logic [23:0] x;
      logic [23:0] y;
      logic        mv;
      logic        fz;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Model state: 0 idle, 1 move, 2 freeze
   int ax = 290, ay = 364, bx = 354, by = 364;
   int mst = 0, mcnt = 0, mfz = 0;
   int dax = 0, day = 0, dbx = 0, dby = 0;
   bit mmov = 1'b0, mfrz = 1'b0;

   function automatic logic [23:0] pk(input int b, input int a);
      return {12'(b), 12'(a)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic plan(input logic [3:0] d, input int x, input int y, input bit blk,
                       output int dx, output int dy);
      dx = 0;
      dy = 0;
      if (!blk) begin
         case (d)
            4'b1000: if (y - 32 >= 108) dy = -4;
            4'b0100: if (y + 32 <= 428) dy = 4;
            4'b0010: if (x - 32 >= 34)  dx = -4;
            4'b0001: if (x + 32 <= 610) dx = 4;
            default: dx = 0;
         endcase
      end
   endtask

   task automatic model_edge(input bit tick, input logic [3:0] d, input bit ba, input bit bb, input bit hr);
      if (hr) begin
         ax = 290; ay = 364; bx = 354; by = 364;
         mst = 2; mfz = 60; mmov = 1'b0; mfrz = 1'b1;
      end else if (tick) begin
         if (mst == 0) begin
            if ($countones(d) == 1) begin
               plan(d, ax, ay, ba, dax, day);
               plan({d[3], d[2], d[0], d[1]}, bx, by, bb, dbx, dby);
               if (dax != 0 || day != 0 || dbx != 0 || dby != 0) begin
                  mst = 1; mcnt = 8; mmov = 1'b1;
               end
            end
         end else if (mst == 1) begin
            ax += dax; ay += day; bx += dbx; by += dby;
            mcnt--;
            if (mcnt == 0) begin
               mst = 0; mmov = 1'b0;
            end
         end else begin
            if (mfz == 1) begin
               mst = 0; mfrz = 1'b0;
            end else begin
               mfz--;
            end
         end
      end
   endtask

   task automatic compare_front(input string tag);
      exp_t e;
      e = sb_q.pop_front();
      chk({tag, ".x"},  {8'd0, u_if.hero_x_pos}, {8'd0, e.x});
      chk({tag, ".y"},  {8'd0, u_if.hero_y_pos}, {8'd0, e.y});
      chk({tag, ".mv"}, {31'd0, u_if.moving},    {31'd0, e.mv});
      chk({tag, ".fz"}, {31'd0, u_if.frozen},    {31'd0, e.fz});
   endtask

   task automatic step(input string tag, input bit tick, input logic [3:0] d,
                       input bit ba, input bit bb, input bit hr);
      @(negedge clk);
      u_if.frame_tick = tick;
      u_if.dir        = d;
      u_if.blocked_a  = ba;
      u_if.blocked_b  = bb;
      u_if.hero_rst   = hr;
      model_edge(tick, d, ba, bb, hr);
      sb_q.push_back('{x: pk(bx, ax), y: pk(by, ay), mv: mmov, fz: mfrz});
      @(posedge clk);
      #1;
      u_if.frame_tick = 1'b0;
      u_if.hero_rst   = 1'b0;
      u_if.dir        = 4'b0000;
      u_if.blocked_a  = 1'b0;
      u_if.blocked_b  = 1'b0;
      compare_front(tag);
   endtask

   // Full tile move with a quiet cycle after every tick to confirm stability.
   task automatic move(input string tag, input logic [3:0] d, input bit ba, input bit bb);
      step(tag, 1'b1, d, ba, bb, 1'b0);
      step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      repeat (8) begin
         step(tag, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
         step(tag, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      u_if.frame_tick = 1'b0;
      u_if.dir        = 4'b0000;
      u_if.blocked_a  = 1'b0;
      u_if.blocked_b  = 1'b0;
      u_if.hero_rst   = 1'b0;

      #12;
      sb_q.push_back('{x: pk(354, 290), y: pk(364, 364), mv: 1'b0, fz: 1'b0});
      compare_front("reset");
      chk("reset_x_const", {8'd0, u_if.hero_x_pos}, {8'd0, 12'd354, 12'd290});
      @(negedge clk);
      rst_n = 1'b1;

      // Right move: A goes right, B mirrors left
      step("r_start", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("r_start_moving", {31'd0, u_if.moving}, 32'd1);
      step("r_t1", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("r_t1_ax", {20'd0, u_if.hero_x_pos[11:0]}, 32'd294);
      chk("r_t1_bx", {20'd0, u_if.hero_x_pos[23:12]}, 32'd350);
      repeat (6) step("r_tn", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("r_t7_moving", {31'd0, u_if.moving}, 32'd1);
      step("r_t8", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("r_t8_x", {8'd0, u_if.hero_x_pos}, {8'd0, 12'd322, 12'd322});
      chk("r_t8_moving", {31'd0, u_if.moving}, 32'd0);

      // Up with B blocked
      move("up_blkb", 4'b1000, 1'b0, 1'b1);
      chk("up_blkb_y", {8'd0, u_if.hero_y_pos}, {8'd0, 12'd364, 12'd332});
      chk("up_blkb_bx", {20'd0, u_if.hero_x_pos[23:12]}, 32'd322);

      // Invalid requests
      step("multi_dir", 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
      step("no_tick", 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("no_tick_moving", {31'd0, u_if.moving}, 32'd0);

      // Respawn mid-move, then full freeze
      step("pre_rst", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
      repeat (3) step("pre_rst_t", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      step("hrst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
      chk("hrst_x", {8'd0, u_if.hero_x_pos}, {8'd0, 12'd354, 12'd290});
      chk("hrst_frozen", {31'd0, u_if.frozen}, 32'd1);
      chk("hrst_moving", {31'd0, u_if.moving}, 32'd0);
      repeat (59) step("frz", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("frz59_frozen", {31'd0, u_if.frozen}, 32'd1);
      chk("frz59_x", {8'd0, u_if.hero_x_pos}, {8'd0, 12'd354, 12'd290});
      step("frz60", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("frz60_frozen", {31'd0, u_if.frozen}, 32'd0);
      chk("frz60_moving", {31'd0, u_if.moving}, 32'd0);
      step("post_frz", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
      chk("post_frz_moving", {31'd0, u_if.moving}, 32'd1);
      repeat (8) step("post_frz_t", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

      // Walk A to (482,108); B mirrors
      repeat (5) move("walk_r", 4'b0001, 1'b0, 1'b0);
      repeat (8) move("walk_u", 4'b1000, 1'b0, 1'b0);
      chk("walk_ax", {20'd0, u_if.hero_x_pos[11:0]}, 32'd482);
      chk("walk_ay", {20'd0, u_if.hero_y_pos[11:0]}, 32'd108);
      chk("walk_bx", {20'd0, u_if.hero_x_pos[23:12]}, 32'd162);

      // Both at top edge: up must not start a move
      step("top_edge", 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
      chk("top_edge_moving", {31'd0, u_if.moving}, 32'd0);
      step("top_edge2", 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("top_edge_y", {8'd0, u_if.hero_y_pos}, {8'd0, 12'd108, 12'd108});

      // Down with A blocked: only B moves
      move("down_blka", 4'b0100, 1'b1, 1'b0);
      chk("down_blka_y", {8'd0, u_if.hero_y_pos}, {8'd0, 12'd140, 12'd108});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
